// File: rtl/busdebugger_cmd_pkg.sv
// Shared command/reply byte codes and controller state encoding for the
// bus debugger serial command path.
package busdebugger_cmd_pkg;

  localparam logic [7:0] CMD_ADDR   = 8'h41;  // 'A'
  localparam logic [7:0] CMD_DUMP   = 8'h44;  // 'D'
  localparam logic [7:0] CMD_EN     = 8'h45;  // 'E'
  localparam logic [7:0] CMD_DIS    = 8'h46;  // 'F'
  localparam logic [7:0] CMD_ARM    = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STATUS = 8'h53;  // 'S'
  localparam logic [7:0] CMD_TRIG   = 8'h54;  // 'T'

  localparam logic [7:0] RPL_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_BUSY = 8'h42;  // 'B'
  localparam logic [7:0] RPL_ERR  = 8'h3F;  // '?'
  localparam logic [7:0] RPL_END  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_REPLY,
    ST_DUMP,
    ST_DUMP_TERM
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Optional N-flop synchroniser followed by a one-cycle rising-edge pulse.
// SYNC_STAGES = 0 gives a plain edge detector for same-domain inputs.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic synced;
  logic prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign synced = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;

      // NOTE: flops use non-blocking assignments so every stage samples the
      // value from before the edge; blocking here would collapse the chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= '0;
        end else begin
          chain[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign synced = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= synced;
  end

  assign pulse = synced & ~prev;

endmodule

// File: rtl/busdebugger_command_ctrl.sv
// Serial command controller: decodes USART command bytes, sequences the
// snooper/dumper and arbitrates the TX byte stream between dumper and replies.
module busdebugger_command_ctrl
  import busdebugger_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  comm_clock,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [7:0]            rx_data,
  output logic                  record_start,
  output logic                  record_trigger,
  input  logic                  record_end,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic                  trigger_enable,
  output logic                  dump_start,
  input  logic                  dump_end,
  input  logic                  dump_valid,
  output logic                  dump_ready,
  input  logic [7:0]            dump_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data
);

  localparam int NBYTES = ADDR_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [7:0]    reply;
  logic          reply_valid;
  logic          armed;
  logic          complete;
  logic [CW-1:0] byte_cnt;
  logic [TW-1:0] timer;

  logic rec_end_pulse;
  logic dump_end_pulse;
  logic accept;
  logic armed_eff;
  logic complete_eff;
  logic in_dump;

  edge_sync #(.SYNC_STAGES(2)) u_rec_end_sync (
    .clk   (comm_clock),
    .rst_n (reset_n),
    .din   (record_end),
    .pulse (rec_end_pulse)
  );

  edge_sync #(.SYNC_STAGES(0)) u_dump_end_edge (
    .clk   (comm_clock),
    .rst_n (reset_n),
    .din   (dump_end),
    .pulse (dump_end_pulse)
  );

  // A capture-complete edge lands before any command decoded in the same
  // cycle, so 'R', 'S' and 'D' all see the post-capture view.
  assign armed_eff    = armed & ~rec_end_pulse;
  assign complete_eff = complete | (armed & rec_end_pulse);
  assign accept       = rx_valid & rx_ready;
  assign in_dump      = (state == ST_DUMP);

  assign record_start = armed;
  assign tx_valid     = reply_valid | (in_dump & dump_valid);
  assign tx_data      = in_dump ? dump_data : reply;
  assign dump_ready   = in_dump & tx_ready;

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      reply          <= '0;
      reply_valid    <= 1'b0;
      rx_ready       <= 1'b0;
      armed          <= 1'b0;
      complete       <= 1'b0;
      byte_cnt       <= '0;
      timer          <= '0;
      trigger_addr   <= '0;
      trigger_enable <= 1'b0;
      record_trigger <= 1'b0;
      dump_start     <= 1'b0;
    end else begin
      armed          <= armed_eff;
      complete       <= complete_eff;
      record_trigger <= 1'b0;
      dump_start     <= 1'b0;

      case (state)
        ST_IDLE: begin
          rx_ready <= 1'b1;
          if (accept) begin
            // Default outcome is a single-byte 'K' reply; commands override.
            state       <= ST_REPLY;
            reply       <= RPL_OK;
            reply_valid <= 1'b1;
            rx_ready    <= 1'b0;
            case (rx_data)
              CMD_ADDR: begin
                state       <= ST_ARG;
                reply_valid <= 1'b0;
                rx_ready    <= 1'b1;
                byte_cnt    <= '0;
                timer       <= '0;
              end
              CMD_ARM: begin
                if (armed_eff) begin
                  reply <= RPL_BUSY;
                end else begin
                  armed    <= 1'b1;
                  complete <= 1'b0;
                end
              end
              CMD_TRIG:   record_trigger <= 1'b1;
              CMD_EN:     trigger_enable <= 1'b1;
              CMD_DIS:    trigger_enable <= 1'b0;
              CMD_STATUS: reply <= {5'b0, complete_eff, trigger_enable, armed_eff};
              CMD_DUMP: begin
                if (armed_eff) begin
                  reply <= RPL_BUSY;
                end else begin
                  dump_start  <= 1'b1;
                  state       <= ST_DUMP;
                  reply_valid <= 1'b0;
                end
              end
              default: reply <= RPL_ERR;
            endcase
          end
        end

        ST_ARG: begin
          if (accept) begin
            trigger_addr <= {trigger_addr[ADDR_WIDTH-9:0], rx_data};
            timer        <= '0;
            byte_cnt     <= byte_cnt + 1'b1;
            if (byte_cnt == LAST_BYTE) begin
              state       <= ST_REPLY;
              reply       <= RPL_OK;
              reply_valid <= 1'b1;
              rx_ready    <= 1'b0;
            end
          end else if (timer == TIMER_MAX) begin
            // Abort keeps whatever bytes were already shifted in.
            state       <= ST_REPLY;
            reply       <= RPL_ERR;
            reply_valid <= 1'b1;
            rx_ready    <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_REPLY, ST_DUMP_TERM: begin
          if (tx_ready) begin
            state       <= ST_IDLE;
            reply_valid <= 1'b0;
            rx_ready    <= 1'b1;
          end
        end

        ST_DUMP: begin
          if (dump_end_pulse) begin
            state       <= ST_DUMP_TERM;
            reply       <= RPL_END;
            reply_valid <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_busdebugger_command_ctrl.sv
// Directed bench for busdebugger_command_ctrl: command replies, argument
// loading and timeout, dump arbitration and reset abandonment.
module tb_busdebugger_command_ctrl;
  import busdebugger_cmd_pkg::*;

  localparam int AW = 32;
  localparam int TO = 16;

  logic          comm_clock = 1'b0;
  logic          reset_n    = 1'b0;
  logic          rx_valid   = 1'b0;
  logic          rx_ready;
  logic [7:0]    rx_data    = '0;
  logic          record_start;
  logic          record_trigger;
  logic          record_end = 1'b0;
  logic [AW-1:0] trigger_addr;
  logic          trigger_enable;
  logic          dump_start;
  logic          dump_end   = 1'b0;
  logic          dump_valid = 1'b0;
  logic          dump_ready;
  logic [7:0]    dump_data  = '0;
  logic          tx_valid;
  logic          tx_ready   = 1'b1;
  logic [7:0]    tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int ds_count = 0;

  busdebugger_command_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .comm_clock     (comm_clock),
    .reset_n        (reset_n),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data),
    .record_start   (record_start),
    .record_trigger (record_trigger),
    .record_end     (record_end),
    .trigger_addr   (trigger_addr),
    .trigger_enable (trigger_enable),
    .dump_start     (dump_start),
    .dump_end       (dump_end),
    .dump_valid     (dump_valid),
    .dump_ready     (dump_ready),
    .dump_data      (dump_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data)
  );

  always #5 comm_clock = ~comm_clock;

  always @(posedge comm_clock) if (dump_start) ds_count++;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    logic got = 1'b0;
    @(negedge comm_clock);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge comm_clock);
    end
    check(64'(got), 64'd1, {tag, "_accept"});
    if (got) begin
      @(posedge comm_clock);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input logic [7:0] exp, input string tag, input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge comm_clock);
      if (tx_valid && tx_ready) begin
        got = 1'b1;
        check(64'(tx_data), 64'(exp), tag);
        break;
      end
    end
    check(64'(got), 64'd1, {tag, "_seen"});
    if (got) begin
      @(posedge comm_clock);
      #1;
    end
  endtask

  task automatic pulse_record_end();
    @(negedge comm_clock);
    record_end = 1'b1;
    repeat (3) @(posedge comm_clock);
    record_end = 1'b0;
    repeat (4) @(posedge comm_clock);
    #1;
  endtask

  initial begin
    logic [7:0] dbytes [3];
    logic       got;
    int         rx_bad;
    int         ds_before;
    int         tv_seen;

    dbytes = '{8'h01, 8'h02, 8'h03};

    // Reset state
    repeat (3) @(negedge comm_clock);
    check(64'({rx_ready, tx_valid, record_start, record_trigger, trigger_enable,
               dump_start, dump_ready}), 64'd0, "reset_outputs");
    check(64'(trigger_addr), 64'd0, "reset_trigger_addr");
    check(64'(tx_data), 64'd0, "reset_tx_data");
    reset_n = 1'b1;

    // Arm, status, capture complete
    send_byte(CMD_ARM, "arm");
    check(64'(tx_valid), 64'd1, "reply_latency");
    check(64'(rx_ready), 64'd0, "rx_ready_low_in_reply");
    expect_tx(RPL_OK, "arm_reply", 10);
    check(64'(record_start), 64'd1, "record_start_armed");
    send_byte(CMD_STATUS, "status1");
    expect_tx(8'h01, "status_armed", 10);
    pulse_record_end();
    check(64'(record_start), 64'd0, "record_start_after_end");
    send_byte(CMD_STATUS, "status2");
    expect_tx(8'h04, "status_complete", 10);

    // Address load and enable
    send_byte(CMD_ADDR, "addr_cmd");
    send_byte(8'h12, "addr_b0");
    send_byte(8'h34, "addr_b1");
    send_byte(8'h56, "addr_b2");
    send_byte(8'h78, "addr_b3");
    expect_tx(RPL_OK, "addr_reply", 10);
    check(64'(trigger_addr), 64'h12345678, "trigger_addr_loaded");
    send_byte(CMD_EN, "enable");
    expect_tx(RPL_OK, "enable_reply", 10);
    check(64'(trigger_enable), 64'd1, "trigger_enable_set");

    // Argument timeout keeps partial shift
    send_byte(CMD_ADDR, "addr2_cmd");
    send_byte(8'hAA, "addr2_b0");
    repeat (10) @(negedge comm_clock);
    check(64'(tx_valid), 64'd0, "no_early_timeout");
    expect_tx(RPL_ERR, "arg_timeout", 40);
    check(64'(trigger_addr), 64'h345678AA, "partial_shift_kept");

    // Forced trigger pulse width
    tx_ready = 1'b0;
    send_byte(CMD_TRIG, "trig");
    check(64'(record_trigger), 64'd1, "record_trigger_high");
    @(posedge comm_clock);
    #1;
    check(64'(record_trigger), 64'd0, "record_trigger_one_cycle");
    tx_ready = 1'b1;
    expect_tx(RPL_OK, "trig_reply", 10);
    send_byte(CMD_STATUS, "status3");
    expect_tx(8'h06, "status_en_complete", 10);

    // Dump with random TX stalls
    ds_before = ds_count;
    rx_bad    = 0;
    send_byte(CMD_DUMP, "dump_cmd");
    check(64'(dump_start), 64'd1, "dump_start_pulse");
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      @(negedge comm_clock);
      dump_valid = 1'b1;
      dump_data  = dbytes[k];
      for (int i = 0; i < 60; i++) begin
        if (i > 0) @(negedge comm_clock);
        tx_ready = (i >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        if (rx_ready) rx_bad++;
        if (tx_ready && tx_valid) begin
          check(64'(tx_data), 64'(dbytes[k]), "dump_byte");
          check(64'(dump_ready), 64'd1, "dump_ready_grant");
          got = 1'b1;
          break;
        end
      end
      check(64'(got), 64'd1, "dump_byte_seen");
      @(posedge comm_clock);
      #1;
      dump_valid = 1'b0;
    end
    @(negedge comm_clock);
    tx_ready = 1'b1;
    dump_end = 1'b1;
    if (rx_ready) rx_bad++;
    @(posedge comm_clock);
    #1;
    expect_tx(RPL_END, "dump_terminator", 10);
    dump_end = 1'b0;
    check(64'(rx_bad), 64'd0, "rx_ready_low_in_dump");
    check(64'(ds_count - ds_before), 64'd1, "dump_start_count");

    // Busy dump and unknown command
    send_byte(CMD_ARM, "arm2");
    expect_tx(RPL_OK, "arm2_reply", 10);
    ds_before = ds_count;
    send_byte(CMD_DUMP, "dump_busy");
    expect_tx(RPL_BUSY, "dump_busy_reply", 10);
    check(64'(ds_count - ds_before), 64'd0, "dump_start_suppressed");
    send_byte(8'h7A, "unknown");
    expect_tx(RPL_ERR, "unknown_reply", 10);

    // Reset in the middle of a stalled dump
    pulse_record_end();
    send_byte(CMD_DUMP, "dump2_cmd");
    @(negedge comm_clock);
    tx_ready   = 1'b0;
    dump_valid = 1'b1;
    dump_data  = 8'h55;
    #1;
    check(64'(tx_valid), 64'd1, "grant_before_reset");
    #1;
    reset_n = 1'b0;
    #1;
    check(64'({rx_ready, tx_valid, record_start, record_trigger, trigger_enable,
               dump_start, dump_ready}), 64'd0, "async_reset_outputs");
    check(64'(trigger_addr), 64'd0, "async_reset_trigger_addr");
    repeat (2) @(negedge comm_clock);
    reset_n    = 1'b1;
    dump_valid = 1'b0;
    tx_ready   = 1'b1;
    tv_seen    = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge comm_clock);
      if (tx_valid) tv_seen++;
    end
    check(64'(tv_seen), 64'd0, "no_terminator_after_reset");
    send_byte(CMD_STATUS, "status4");
    expect_tx(8'h00, "status_after_reset", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
